// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding, port indices and helpers for memory-port arbitration
package mem_port_arbiter_pkg;

  typedef logic [31:0] word_t;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  function automatic word_t stall_next(input word_t cnt, input logic waiting);
    return waiting ? cnt + 32'd1 : cnt;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and statistics signals of the shared memory port
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic  req0;
  logic  req1;
  logic  mem_ready;
  word_t mem_rdata;
  logic  mem_req;
  logic  mem_sel;
  logic  rvalid0;
  logic  rvalid1;
  word_t rdata0;
  word_t rdata1;
  word_t stall0;
  word_t stall1;

  modport slave (
    input  req0, req1, mem_ready, mem_rdata,
    output mem_req, mem_sel, rvalid0, rvalid1, rdata0, rdata1, stall0, stall1
  );

  modport master (
    output req0, req1, mem_ready, mem_rdata,
    input  mem_req, mem_sel, rvalid0, rvalid1, rdata0, rdata1, stall0, stall1
  );

endinterface

// File: rtl/mem_port_arbiter_arb_prio_guard.sv
// rtl/mem_port_arbiter_arb_prio_guard.sv - port-1 priority with a consecutive-grant guard for port 0
module arb_prio_guard
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_BURST_MAX = 4,
  parameter int CNT_W          = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic req0,
  input  logic req1,
  input  logic grant,
  output logic winner
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(DATA_BURST_MAX);

  logic [CNT_W-1:0] burst_cnt;
  logic             at_limit;

  assign at_limit = (burst_cnt == BURST_LIM);
  assign winner   = (req1 && !(req0 && at_limit)) ? PORT_MEM : PORT_IF;

  // Only port-1 wins taken against a waiting fetch count toward the guard.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      burst_cnt <= '0;
    end else if (grant) begin
      if (winner == PORT_MEM && req0) begin
        burst_cnt <= at_limit ? burst_cnt : burst_cnt + CNT_W'(1);
      end else begin
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_BURST_MAX = 4,
  parameter int CNT_W          = 4
) (
  input logic          clk,
  input logic          rstn,
  mem_port_arbiter_if.slave bus
);

  logic [0:0] state;
  logic       sel;
  logic       grant;
  logic       winner;
  logic       serving;
  logic       done;
  word_t      stall0_q;
  word_t      stall1_q;

  assign grant   = (state == IDLE) && (bus.req0 || bus.req1);
  assign serving = (state == SERVE);
  assign done    = serving && bus.mem_ready;

  arb_prio_guard #(
    .DATA_BURST_MAX(DATA_BURST_MAX),
    .CNT_W         (CNT_W)
  ) u_guard (
    .clk   (clk),
    .rstn  (rstn),
    .req0  (bus.req0),
    .req1  (bus.req1),
    .grant (grant),
    .winner(winner)
  );

  // sel only moves on the grant edge so the external muxes hold for the whole access.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      sel   <= PORT_IF;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= SERVE;
            sel   <= winner;
          end
        end
        SERVE: begin
          if (bus.mem_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall0_q <= '0;
      stall1_q <= '0;
    end else begin
      stall0_q <= stall_next(stall0_q, bus.req0 && !(serving && sel == PORT_IF));
      stall1_q <= stall_next(stall1_q, bus.req1 && !(serving && sel == PORT_MEM));
    end
  end

  assign bus.mem_req = serving;
  assign bus.mem_sel = sel;
  assign bus.rvalid0 = done && (sel == PORT_IF);
  assign bus.rvalid1 = done && (sel == PORT_MEM);
  assign bus.rdata0  = bus.rvalid0 ? bus.mem_rdata : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.mem_rdata : '0;
  assign bus.stall0  = stall0_q;
  assign bus.stall1  = stall1_q;

endmodule
